// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write-side arbiter and the FIFO top.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int DATASIZE_DEF = 8;
  localparam int ADDRSIZE_DEF = 4;
  localparam int NREQ_DEF     = 4;
  localparam int MAXBURST_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
// slave = arbiter side, master = producers/FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DATASIZE = DATASIZE_DEF
);
  localparam int IDXW = $clog2(NREQ);

  logic [NREQ-1:0]          req;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          gnt;
  logic                     winc;
  logic [DATASIZE-1:0]      wdata;
  logic                     wfull;
  logic                     busy;
  logic [IDXW-1:0]          owner;

  modport slave  (input  req, req_data, wfull, output gnt, winc, wdata, busy, owner);
  modport master (output req, req_data, wfull, input  gnt, winc, wdata, busy, owner);

endinterface

// File: rtl/fifo_wr_arbiter_chk.sv
// Invariant checker for the write arbiter; simulation-only properties.
module fifo_wr_arbiter_chk #(
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4,
  parameter int CNTW     = 3
) (
  input logic            clk,
  input logic            rst,
  input logic            winc,
  input logic            wfull,
  input logic [NREQ-1:0] gnt,
  input logic [CNTW-1:0] burst_cnt
);

  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(winc && wfull));
  a_gnt_onehot0:        assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_implies_winc:   assert property (@(posedge clk) disable iff (rst) (gnt != {NREQ{1'b0}}) |-> winc);
  a_burst_cnt_bound:    assert property (@(posedge clk) disable iff (rst) int'(burst_cnt) < MAXBURST);

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin pick: first requester with req set, searching cyclically
// from the one after the last owner. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] owner,
  output logic [IDXW-1:0] next_idx,
  output logic            any_req
);

  logic            found;
  logic [IDXW-1:0] cand;

  // Walk owner+1 .. owner+NREQ (mod NREQ) and latch the first hit.
  always_comb begin
    next_idx = owner;
    found    = 1'b0;
    cand     = owner;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = IDXW'((int'(owner) + k) % NREQ);
      next_idx = (!found && req[cand]) ? cand : next_idx;
      found    = found | req[cand];
    end
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ requesters.
// One idle cycle arbitrates, then the owner writes up to MAXBURST words.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input logic               wclk,
  input logic               wrst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CNTW = $clog2(MAXBURST) + 1;

  arb_state_t      state_r, state_nxt;
  logic [IDXW-1:0] owner_r, owner_nxt, pick_idx;
  logic [CNTW-1:0] burst_cnt_r, burst_cnt_nxt;
  logic            any_req;
  logic            winc_s;
  logic [NREQ-1:0] gnt_s;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req      (bus.req),
    .owner    (owner_r),
    .next_idx (pick_idx),
    .any_req  (any_req)
  );

  // Next state, burst counter and write enable; reset suppresses the write in its own cycle.
  always_comb begin
    state_nxt     = state_r;
    owner_nxt     = owner_r;
    burst_cnt_nxt = burst_cnt_r;
    winc_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req) begin
          owner_nxt     = pick_idx;
          burst_cnt_nxt = {CNTW{1'b0}};
          state_nxt     = BURST;
        end else begin
          state_nxt = IDLE;
        end
      end
      BURST: begin
        if (!bus.req[owner_r]) begin
          state_nxt = IDLE;
        end else if (bus.wfull || wrst) begin
          state_nxt = BURST;
        end else begin
          winc_s = 1'b1;
          if (burst_cnt_r == CNTW'(MAXBURST - 1)) begin
            state_nxt     = IDLE;
            burst_cnt_nxt = {CNTW{1'b0}};
          end else begin
            burst_cnt_nxt = burst_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign gnt_s = winc_s ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_r) : {NREQ{1'b0}};

  // State, owner and burst counter registers; owner resets to the last index so requester 0 wins first.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_r     <= IDLE;
      owner_r     <= IDXW'(NREQ - 1);
      burst_cnt_r <= {CNTW{1'b0}};
    end else begin
      state_r     <= state_nxt;
      owner_r     <= owner_nxt;
      burst_cnt_r <= burst_cnt_nxt;
    end
  end

  assign bus.winc  = winc_s;
  assign bus.gnt   = gnt_s;
  assign bus.wdata = bus.req_data[owner_r*DATASIZE +: DATASIZE];
  assign bus.busy  = (state_r == BURST);
  assign bus.owner = owner_r;

  fifo_wr_arbiter_chk #(.NREQ(NREQ), .MAXBURST(MAXBURST), .CNTW(CNTW)) u_chk (
    .clk       (wclk),
    .rst       (wrst),
    .winc      (winc_s),
    .wfull     (bus.wfull),
    .gnt       (gnt_s),
    .burst_cnt (burst_cnt_r)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, hand-written corner sequences,
// and a randomized run against a grant-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DATASIZE = 8;
  localparam int MAXBURST = 4;
  localparam logic [31:0] TBL_DATA = 32'hA3A2A1A0;

  logic wclk;
  logic wrst;
  int   checks;
  int   errors;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DATASIZE(DATASIZE)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DATASIZE(DATASIZE), .MAXBURST(MAXBURST)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       wfull;
    logic       chk;
    logic       winc;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl [$];

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Apply inputs just after the rising edge, return at the falling edge for sampling.
  task automatic drive(input logic [3:0] r, input logic f, input logic rs);
    @(posedge wclk);
    #1;
    bus.req   = r;
    bus.wfull = f;
    wrst      = rs;
    @(negedge wclk);
  endtask

  task automatic expect_out(input string tag, input logic ew, input logic [3:0] eg,
                            input logic [1:0] eo, input logic eb);
    logic [7:0] ed;
    check({tag, " winc"},  32'(bus.winc),  32'(ew));
    check({tag, " gnt"},   32'(bus.gnt),   32'(eg));
    check({tag, " owner"}, 32'(bus.owner), 32'(eo));
    check({tag, " busy"},  32'(bus.busy),  32'(eb));
    if (ew) begin
      ed = 8'hA0 | {6'b000000, eo};
      check({tag, " wdata"}, 32'(bus.wdata), 32'(ed));
    end
  endtask

  function automatic void add(input logic rs, input logic [3:0] r, input logic f, input logic c,
                              input logic w, input logic [3:0] g, input logic [1:0] o, input logic b);
    vec_t v;
    v.rst = rs; v.req = r; v.wfull = f; v.chk = c;
    v.winc = w; v.gnt = g; v.owner = o; v.busy = b;
    tbl.push_back(v);
  endfunction

  // Random-phase state
  logic [3:0]  rq, rq_prev, gnt_seen;
  logic [31:0] rdata;
  logic        wf, ew, busy_prev;
  int seq[NREQ], nseq[NREQ], words[NREQ], gcnt[NREQ], waitc[NREQ];
  int m_active, m_owner, m_left, idx, c, base, found, total;
  int order[4];

  initial begin
    checks       = 0;
    errors       = 0;
    wrst         = 1'b1;
    bus.req      = 4'b0000;
    bus.req_data = TBL_DATA;
    bus.wfull    = 1'b0;

    // ---------------- vector table ----------------
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0);
    for (int w = 0; w < 4; w++) add(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int w = 0; w < 4; w++) add(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    order = '{1, 2, 3, 0};
    base = 0;
    for (int n = 0; n < 4; n++) begin
      add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4'b0000, 2'(base), 1'b0);
      for (int w = 0; w < 4; w++)
        add(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 4'(1 << order[n]), 2'(order[n]), 1'b1);
      base = order[n];
    end
    add(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
    add(1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd3, 1'b0);
    for (int w = 0; w < 2; w++) add(1'b0, 4'b0101, 1'b0, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1);
    add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int w = 0; w < 4; w++) add(1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1);
    add(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b0);

    foreach (tbl[n]) begin
      drive(tbl[n].req, tbl[n].wfull, tbl[n].rst);
      if (tbl[n].chk)
        expect_out($sformatf("vec%0d", n), tbl[n].winc, tbl[n].gnt, tbl[n].owner, tbl[n].busy);
    end

    // ---------------- wfull held mid-burst ----------------
    drive(4'b1111, 1'b0, 1'b1);
    drive(4'b1111, 1'b0, 1'b0); expect_out("full idle", 1'b0, 4'b0000, 2'd0 + 2'd3, 1'b0);
    drive(4'b1111, 1'b0, 1'b0); expect_out("full first", 1'b1, 4'b0001, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1, 1'b0); expect_out("full hold", 1'b0, 4'b0000, 2'd0, 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      drive(4'b1111, 1'b0, 1'b0); expect_out("full resume", 1'b1, 4'b0001, 2'd0, 1'b1);
    end
    drive(4'b1111, 1'b0, 1'b0); expect_out("full gap", 1'b0, 4'b0000, 2'd0, 1'b0);
    drive(4'b1111, 1'b0, 1'b0); expect_out("full rotate", 1'b1, 4'b0010, 2'd1, 1'b1);

    // ---------------- reset during owner 2 burst ----------------
    drive(4'b1111, 1'b0, 1'b1);
    drive(4'b1111, 1'b0, 1'b0); expect_out("rst idle", 1'b0, 4'b0000, 2'd3, 1'b0);
    for (int o = 0; o < 2; o++) begin
      for (int w = 0; w < 4; w++) begin
        drive(4'b1111, 1'b0, 1'b0); expect_out("rst pre", 1'b1, 4'(1 << o), 2'(o), 1'b1);
      end
      drive(4'b1111, 1'b0, 1'b0); expect_out("rst gap", 1'b0, 4'b0000, 2'(o), 1'b0);
    end
    for (int w = 0; w < 2; w++) begin
      drive(4'b1111, 1'b0, 1'b0); expect_out("rst own2", 1'b1, 4'b0100, 2'd2, 1'b1);
    end
    drive(4'b1111, 1'b0, 1'b1); expect_out("rst cycle", 1'b0, 4'b0000, 2'd2, 1'b1);
    drive(4'b1111, 1'b0, 1'b0); expect_out("rst after", 1'b0, 4'b0000, 2'd3, 1'b0);
    drive(4'b1111, 1'b0, 1'b0); expect_out("rst first", 1'b1, 4'b0001, 2'd0, 1'b1);

    // ---------------- randomized run against grant-level model ----------------
    drive(4'b0000, 1'b0, 1'b1);
    rq = 4'b0000; gnt_seen = 4'b0000; busy_prev = 1'b0;
    m_active = 0; m_owner = NREQ - 1; m_left = 0;
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0; nseq[i] = 0; words[i] = 0; gcnt[i] = 0; waitc[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rq_prev = rq;
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i]) begin
          if (gnt_seen[i] && ($urandom_range(3, 0) == 0)) rq[i] = 1'b0;
        end else if ($urandom_range(1, 0) == 1) begin
          rq[i] = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) rdata[i*8 +: 8] = {3'(i), 5'(seq[i])};
      wf = ($urandom_range(3, 0) == 0);
      @(posedge wclk);
      #1;
      bus.req = rq; bus.req_data = rdata; bus.wfull = wf; wrst = 1'b0;
      @(negedge wclk);

      ew = (m_active != 0) && rq[m_owner] && !wf;
      check("rnd winc",  32'(bus.winc),  32'(ew));
      check("rnd gnt",   32'(bus.gnt),   ew ? (32'd1 << m_owner) : 32'd0);
      check("rnd busy",  32'(bus.busy),  32'(m_active));
      check("rnd owner", 32'(bus.owner), 32'(m_owner));
      check("rnd winc_and_full", 32'(bus.winc & bus.wfull), 32'd0);
      if (ew) check("rnd wdata", 32'(bus.wdata), 32'(rdata[m_owner*8 +: 8]));

      if (bus.winc === 1'b1) begin
        idx = int'(bus.wdata[6:5]);
        words[idx]++;
        check("rnd order", 32'(bus.wdata[4:0]), 32'(nseq[idx] % 32));
        nseq[idx]++;
      end
      gnt_seen = bus.gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.gnt[i] === 1'b1) begin
          gcnt[i]++;
          seq[i]++;
        end
      end
      if (bus.busy && !busy_prev) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i == int'(bus.owner) || !rq_prev[i]) begin
            waitc[i] = 0;
          end else begin
            waitc[i]++;
            check("rnd wait", 32'(waitc[i] <= NREQ - 1), 32'd1);
          end
        end
      end
      busy_prev = bus.busy;

      // Grant-level model: pick cyclically after last owner, then count down words left.
      if (m_active == 0) begin
        if (rq != 4'b0000) begin
          base = m_owner; found = 0;
          for (int k = 1; k <= NREQ; k++) begin
            c = (base + k) % NREQ;
            if (found == 0 && rq[c]) begin
              m_owner = c;
              found = 1;
            end
          end
          m_active = 1;
          m_left = MAXBURST;
        end
      end else if (!rq[m_owner]) begin
        m_active = 0;
      end else if (!wf) begin
        m_left--;
        if (m_left == 0) m_active = 0;
      end
    end

    total = 0;
    for (int i = 0; i < NREQ; i++) begin
      check($sformatf("rnd words_vs_gnt%0d", i), 32'(words[i]), 32'(gcnt[i]));
      total += gcnt[i];
    end
    check("rnd activity", 32'(total > 1000), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
